vga_glyph_fetch: RTL and testbench

VGA_GLYPH_FETCH -- requirements
Module: vga_glyph_fetch

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_pipe_delay.sv | 30 +++
 rtl/vga_glyph_fetch.sv | 143 ++++++++++++++
 tb/tb_vga_glyph_fetch.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants, payload types and address helper for the VGA text-mode pipeline.
package vga_pkg;

    localparam int unsigned COLS     = 80;
    localparam int unsigned ROWS     = 30;
    localparam int unsigned GLYPH_W  = 8;
    localparam int unsigned GLYPH_H  = 16;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned CODE_W   = 8;
    localparam int unsigned COLOR_W  = 8;
    localparam int unsigned MODE_W   = 3;
    localparam int unsigned GX_W     = $clog2(GLYPH_W);
    localparam int unsigned GY_W     = $clog2(GLYPH_H);

    localparam logic [MODE_W-1:0] MODE_OFF  = 3'b000;
    localparam logic [MODE_W-1:0] MODE_GFX  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_TEXT = 3'b100;

    typedef struct packed {
        logic [COLOR_W-1:0] bg;
        logic [CODE_W-1:0]  code;
    } char_word_t;

    // Row-major cell index of the 8x16 cell containing pixel (h, v).
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [CNT_W-1:0] h,
                                                    input logic [CNT_W-1:0] v);
        return ADDR_W'(v[CNT_W-1:GY_W]) * ADDR_W'(COLS) + ADDR_W'(h[CNT_W-1:GX_W]);
    endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// Fixed-depth shift register advanced on enable; aligns side-band signals with the fetch pipeline.
module vga_pipe_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 3
) (
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stage[i] <= '0;
            end
        end else if (i_en) begin
            r_stage[0] <= i_d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_glyph_fetch.sv
// Three-stage text-mode glyph fetch: cell address -> char RAM -> font ROM, with aligned sync/mode.
// Optional cursor overlay with frame blink is enabled by defining VGA_CURSOR_EN.
module vga_glyph_fetch
    import vga_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 en,
    input  logic [CNT_W-1:0]     hCount,
    input  logic [CNT_W-1:0]     vCount,
    input  logic                 brightIn,
    input  logic                 hSyncIn,
    input  logic                 vSyncIn,
    input  logic [MODE_W-1:0]    modeSel,
`ifdef VGA_CURSOR_EN
    input  logic [6:0]           cursorCol,
    input  logic [4:0]           cursorRow,
`endif
    output logic [ADDR_W-1:0]    charAddr,
    input  logic [15:0]          charData,
    output logic [ADDR_W-1:0]    fontAddr,
    input  logic [GLYPH_W-1:0]   fontData,
    output logic [GLYPH_W-1:0]   pixelRow,
    output logic [COLOR_W-1:0]   bgColor,
    output logic [GX_W-1:0]      glyphX,
    output logic [MODE_W-1:0]    pixelData,
    output logic                 pixEn,
    output logic                 bright,
    output logic                 hSync,
    output logic                 vSync
);

    logic [ADDR_W-1:0]  r_char_addr;
    logic [ADDR_W-1:0]  r_font_addr;
    logic [GX_W-1:0]    r_col_a;
    logic [GX_W-1:0]    r_col_b;
    logic [GX_W-1:0]    r_glyph_x;
    logic [GY_W-1:0]    r_row_a;
    logic [COLOR_W-1:0] r_bg_b;
    logic [COLOR_W-1:0] r_bg_c;
    logic [GLYPH_W-1:0] r_pixel_row;
    logic [MODE_W-1:0]  r_mode;
    logic               r_cur_a;
    logic               r_cur_b;

    logic               w_in_range;
    logic               w_frame_start;
    logic               w_cur_hit;
    logic [MODE_W-1:0]  w_mode_nxt;
    logic [3:0]         w_side;
    char_word_t         w_char;

    assign w_char        = char_word_t'(charData);
    assign w_in_range    = (hCount < CNT_W'(H_ACTIVE)) && (vCount < CNT_W'(V_ACTIVE));
    assign w_frame_start = (hCount == '0) && (vCount == '0);
    assign w_mode_nxt    = w_frame_start ? modeSel : r_mode;

`ifdef VGA_CURSOR_EN
    logic [5:0] r_blink;

    // Underline cursor on the last two glyph rows, visible during the first half of the blink period.
    assign w_cur_hit = w_in_range && !r_blink[5]
                    && (hCount[CNT_W-1:GX_W] == cursorCol)
                    && (vCount[CNT_W-1:GY_W] == {1'b0, cursorRow})
                    && (vCount[GY_W-1:1] == 3'b111);

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_blink <= '0;
        end else if (en && w_frame_start) begin
            r_blink <= r_blink + 6'd1;
        end
    end
`else
    assign w_cur_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_char_addr <= '0;
            r_font_addr <= '0;
            r_col_a     <= '0;
            r_col_b     <= '0;
            r_glyph_x   <= '0;
            r_row_a     <= '0;
            r_bg_b      <= '0;
            r_bg_c      <= '0;
            r_pixel_row <= '0;
            r_mode      <= '0;
            r_cur_a     <= 1'b0;
            r_cur_b     <= 1'b0;
        end else if (en) begin
            // Stage A: cell address and glyph coordinates
            r_char_addr <= w_in_range ? cell_addr(hCount, vCount) : '0;
            r_col_a     <= hCount[GX_W-1:0];
            r_row_a     <= vCount[GY_W-1:0];
            r_cur_a     <= w_cur_hit;
            r_mode      <= w_mode_nxt;
            // Stage B: character word -> font address
            r_font_addr <= {w_char.code, r_row_a};
            r_bg_b      <= w_char.bg;
            r_col_b     <= r_col_a;
            r_cur_b     <= r_cur_a;
            // Stage C: font row out
            r_pixel_row <= r_cur_b ? {GLYPH_W{1'b1}} : fontData;
            r_bg_c      <= r_bg_b;
            r_glyph_x   <= r_col_b;
        end
    end

    vga_pipe_delay #(
        .WIDTH (4),
        .DEPTH (3)
    ) u_side_delay (
        .i_clk   (clk),
        .i_clr_n (clr),
        .i_en    (en),
        .i_d     ({w_in_range & brightIn, brightIn, hSyncIn, vSyncIn}),
        .o_q     (w_side)
    );

    vga_pipe_delay #(
        .WIDTH (MODE_W),
        .DEPTH (3)
    ) u_mode_delay (
        .i_clk   (clk),
        .i_clr_n (clr),
        .i_en    (en),
        .i_d     (w_mode_nxt),
        .o_q     (pixelData)
    );

    assign charAddr = r_char_addr;
    assign fontAddr = r_font_addr;
    assign pixelRow = r_pixel_row;
    assign bgColor  = r_bg_c;
    assign glyphX   = r_glyph_x;
    assign pixEn    = w_side[3];
    assign bright   = w_side[2];
    assign hSync    = w_side[1];
    assign vSync    = w_side[0];

endmodule

// File: tb/tb_vga_glyph_fetch.sv
// Self-checking bench for vga_glyph_fetch with behavioural RAM/ROM and a per-tick scoreboard.
module tb_vga_glyph_fetch;

    logic        clk = 1'b0;
    logic        clr;
    logic        en;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        brightIn;
    logic        hSyncIn;
    logic        vSyncIn;
    logic [2:0]  modeSel;
    logic [11:0] charAddr;
    logic [15:0] charData;
    logic [11:0] fontAddr;
    logic [7:0]  fontData;
    logic [7:0]  pixelRow;
    logic [7:0]  bgColor;
    logic [2:0]  glyphX;
    logic [2:0]  pixelData;
    logic        pixEn;
    logic        bright;
    logic        hSync;
    logic        vSync;

    logic [15:0] ram [4096];
    logic [7:0]  rom [4096];

    assign charData = ram[charAddr];
    assign fontData = rom[fontAddr];

    always #5 clk = ~clk;

    vga_glyph_fetch dut (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .hCount    (hCount),
        .vCount    (vCount),
        .brightIn  (brightIn),
        .hSyncIn   (hSyncIn),
        .vSyncIn   (vSyncIn),
        .modeSel   (modeSel),
`ifdef VGA_CURSOR_EN
        .cursorCol (7'd127),
        .cursorRow (5'd31),
`endif
        .charAddr  (charAddr),
        .charData  (charData),
        .fontAddr  (fontAddr),
        .fontData  (fontData),
        .pixelRow  (pixelRow),
        .bgColor   (bgColor),
        .glyphX    (glyphX),
        .pixelData (pixelData),
        .pixEn     (pixEn),
        .bright    (bright),
        .hSync     (hSync),
        .vSync     (vSync)
    );

    typedef struct packed {
        logic [11:0] addr;
        logic [11:0] faddr;
        logic [7:0]  prow;
        logic [7:0]  bg;
        logic [2:0]  gx;
        logic [2:0]  mode;
        logic        pe;
        logic        b;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t        q[$];
    logic [2:0]  m_mode;
    logic [11:0] cur_addr;
    logic [11:0] cur_faddr;
    logic [25:0] cur_out;
    logic        have_out;
    int          n_cmp;
    int          n_err;

    // One enabled clock: model computes what each stage must show, from pixel coordinates alone.
    task automatic do_tick(input logic [9:0] h, input logic [9:0] v, input logic b,
                           input logic hs, input logic vs, input logic [2:0] ms);
        exp_t        e;
        exp_t        f;
        logic        inr;
        logic [25:0] act;
        logic [25:0] want;
        hCount = h; vCount = v; brightIn = b; hSyncIn = hs; vSyncIn = vs; modeSel = ms;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        inr    = (int'(h) < 640) && (int'(v) < 480);
        e.addr = inr ? 12'((int'(v) / 16) * 80 + int'(h) / 8) : 12'd0;
        e.faddr = {ram[e.addr][7:0], v[3:0]};
        e.prow = rom[e.faddr];
        e.bg   = ram[e.addr][15:8];
        e.gx   = h[2:0];
        if (h == 10'd0 && v == 10'd0) m_mode = ms;
        e.mode = m_mode;
        e.pe   = inr & b;
        e.b    = b;
        e.hs   = hs;
        e.vs   = vs;
        q.push_back(e);
        n_cmp++;
        if (charAddr !== e.addr) begin
            n_err++;
            $display("FAIL charAddr h=%0d v=%0d got %0d exp %0d", h, v, charAddr, e.addr);
        end
        cur_addr = e.addr;
        if (q.size() >= 2) begin
            f = q[q.size()-2];
            n_cmp++;
            if (fontAddr !== f.faddr) begin
                n_err++;
                $display("FAIL fontAddr got %h exp %h", fontAddr, f.faddr);
            end
            cur_faddr = f.faddr;
        end
        act = {pixelRow, bgColor, glyphX, pixelData, pixEn, bright, hSync, vSync};
        if (q.size() == 3) begin
            f    = q.pop_front();
            want = {f.prow, f.bg, f.gx, f.mode, f.pe, f.b, f.hs, f.vs};
            n_cmp++;
            if (act !== want) begin
                n_err++;
                $display("FAIL outputs t=%0t got %h exp %h", $time, act, want);
            end
            cur_out  = want;
            have_out = 1'b1;
        end else begin
            n_cmp++;
            if ({pixelData, pixEn, bright, hSync, vSync} !== 7'd0) begin
                n_err++;
                $display("FAIL fill got %b exp 0000000", {pixelData, pixEn, bright, hSync, vSync});
            end
        end
    endtask

    // Disabled clock with scrambled inputs: every register must hold.
    task automatic do_gap();
        hCount = 10'($urandom); vCount = 10'($urandom); brightIn = 1'($urandom);
        hSyncIn = 1'($urandom); vSyncIn = 1'($urandom); modeSel = 3'($urandom);
        en = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (charAddr !== cur_addr) begin
            n_err++;
            $display("FAIL hold_charAddr got %0d exp %0d", charAddr, cur_addr);
        end
        if (q.size() != 1) begin
            n_cmp++;
            if (fontAddr !== cur_faddr) begin
                n_err++;
                $display("FAIL hold_fontAddr got %h exp %h", fontAddr, cur_faddr);
            end
        end
        if (have_out) begin
            n_cmp++;
            if ({pixelRow, bgColor, glyphX, pixelData, pixEn, bright, hSync, vSync} !== cur_out) begin
                n_err++;
                $display("FAIL hold_out got %h exp %h",
                         {pixelRow, bgColor, glyphX, pixelData, pixEn, bright, hSync, vSync}, cur_out);
            end
        end
    endtask

    task automatic do_reset(input logic en_val);
        clr = 1'b0;
        en  = en_val;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({charAddr, fontAddr, pixelRow, bgColor, glyphX, pixelData, pixEn, bright, hSync, vSync}
            !== 50'd0) begin
            n_err++;
            $display("FAIL reset got %h exp 0",
                     {charAddr, fontAddr, pixelRow, bgColor, glyphX, pixelData, pixEn, bright, hSync, vSync});
        end
        clr = 1'b1;
        en  = 1'b0;
        q.delete();
        m_mode    = 3'b000;
        cur_addr  = 12'd0;
        cur_faddr = 12'd0;
        have_out  = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0; en = 1'b1; hCount = 10'd5; vCount = 10'd5;
        brightIn = 1'b1; hSyncIn = 1'b1; vSyncIn = 1'b1; modeSel = 3'b111;
        repeat (2) @(posedge clk);
        do_reset(1'b1);
    endtask

    task automatic test_text_row();
        for (int i = 0; i < 10; i++) begin
            do_tick(10'(i), 10'd0, 1'b1, 1'b0, 1'b0, 3'b100);
            if (i >= 2 && i < 10) begin
                n_cmp++;
                if ({pixelRow, bgColor, glyphX, pixEn} !== {8'h18, 8'h1E, 3'(i - 2), 1'b1}) begin
                    n_err++;
                    $display("FAIL case1 i=%0d got %h exp %h", i, {pixelRow, bgColor, glyphX, pixEn},
                             {8'h18, 8'h1E, 3'(i - 2), 1'b1});
                end
            end
        end
    endtask

    task automatic test_boundary();
        do_tick(10'd639, 10'd479, 1'b1, 1'b1, 1'b0, 3'b010);
        n_cmp++;
        if (charAddr !== 12'd2399) begin
            n_err++;
            $display("FAIL last_cell got %0d exp 2399", charAddr);
        end
        do_tick(10'd645, 10'd100, 1'b1, 1'b0, 1'b1, 3'b010);
        n_cmp++;
        if (charAddr !== 12'd0) begin
            n_err++;
            $display("FAIL hblank_addr got %0d exp 0", charAddr);
        end
        do_tick(10'd0, 10'd480, 1'b1, 1'b0, 1'b0, 3'b010);
        do_tick(10'd632, 10'd16, 1'b1, 1'b0, 1'b0, 3'b010);
        n_cmp++;
        if (pixEn !== 1'b0) begin
            n_err++;
            $display("FAIL hblank_pixEn got %b exp 0", pixEn);
        end
        do_tick(10'd8, 10'd464, 1'b0, 1'b0, 1'b0, 3'b010);
        do_gap();
        do_tick(10'd799, 10'd524, 1'b1, 1'b1, 1'b1, 3'b010);
    endtask

    task automatic test_mode_change();
        for (int i = 0; i < 4; i++) begin
            do_tick(10'(100 + i), 10'd200, 1'b1, 1'b0, 1'b0, 3'b001);
            n_cmp++;
            if (pixelData !== 3'b100) begin
                n_err++;
                $display("FAIL mode_hold i=%0d got %b exp 100", i, pixelData);
            end
        end
        do_tick(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 3'b001);
        do_tick(10'd1, 10'd0, 1'b1, 1'b0, 1'b0, 3'b110);
        n_cmp++;
        if (pixelData !== 3'b100) begin
            n_err++;
            $display("FAIL mode_early got %b exp 100", pixelData);
        end
        do_tick(10'd2, 10'd0, 1'b1, 1'b0, 1'b0, 3'b110);
        n_cmp++;
        if (pixelData !== 3'b001) begin
            n_err++;
            $display("FAIL mode_switch got %b exp 001", pixelData);
        end
    endtask

    task automatic test_reset_midline();
        do_tick(10'd300, 10'd40, 1'b1, 1'b0, 1'b0, 3'b000);
        do_tick(10'd301, 10'd40, 1'b1, 1'b0, 1'b0, 3'b000);
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            do_tick(10'(302 + i), 10'd40, 1'b1, 1'b1, 1'b0, 3'b000);
        end
        n_cmp++;
        if ({pixEn, hSync, pixelData} !== 5'b11000) begin
            n_err++;
            $display("FAIL release got %b exp 11000", {pixEn, hSync, pixelData});
        end
    endtask

    task automatic test_random();
        logic [9:0] h;
        logic [9:0] v;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 20) begin
                do_gap();
            end else if ($urandom_range(0, 199) == 0) begin
                do_reset(1'($urandom));
            end else begin
                h = 10'($urandom_range(0, 799));
                v = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 479));
                if ($urandom_range(0, 39) == 0) begin
                    h = 10'd0;
                    v = 10'd0;
                end
                do_tick(h, v, 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        m_mode = 3'b000; cur_addr = 12'd0; cur_faddr = 12'd0; cur_out = '0; have_out = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 16'($urandom);
            rom[i] = 8'($urandom);
        end
        ram[0]      = 16'h1E41;
        rom[12'h410] = 8'h18;
        test_reset();
        test_text_row();
        test_boundary();
        test_mode_change();
        test_reset_midline();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
